pipeline_hazard_ctrl: RTL and testbench
=======================================

PIPELINE_HAZARD_CTRL -- requirements
Module: pipeline_hazard_ctrl

Interface
REQ-001 Parameter MEM_TIMEOUT, default 15, is the maximum number of consecutive data-memory wait cycles before forced resume.
REQ-002 Parameter PERF_W, default 16, is the width of each performance counter.
REQ-003 clock  in  1  pipeline clock; all state SHALL update on its rising edge.
REQ-004 reset  in  1  reset, synchronous, active-high.
REQ-005 id_rs, id_rt  in  5 each  source register numbers of the instruction in ID.
REQ-006 id_uses_rt  in  1  ID instruction reads rt as a source.
REQ-007 ex_memread, ex_rt  in  1, 5  MemRead and load-destination rt held in ID/EX.
REQ-008 mem_pcsrc  in  2  PCsrc in EX/MEM; nonzero means redirect.
REQ-009 dmem_req, dmem_ready  in  1 each  MEM-stage access request and memory completion.
REQ-010 pc_write, if_id_write, id_ex_write, ex_mem_write, mem_wb_write  out  1 each  register write enables.
REQ-011 if_id_reset, id_ex_reset, ex_mem_reset  out  1 each  synchronous clear requests to pipeline registers.
REQ-012 mem_timeout_err  out  1  sticky error flag.
REQ-013 state_o  out  2  current FSM state, debug only.

Function
REQ-014 The block SHALL have states RUN=0, MEM_WAIT=1 and TIMEOUT_RESUME=2, with 3 unused and recovering to RUN.
REQ-015 Outputs SHALL be a combinational decode of the state and inputs, with zero added latency.
REQ-016 Per-cycle priority SHALL be: memory wait, then redirect, then load-use, then normal.
- REQ-017 Memory wait SHALL be dmem_req=1 and dmem_ready=0, outside TIMEOUT_RESUME.
  - All five write enables SHALL be 0 and all resets SHALL be 0.
  - The FSM SHALL go RUN->MEM_WAIT.
  - A wait counter SHALL be cleared on entry and incremented each cycle in MEM_WAIT.
REQ-018 In MEM_WAIT, dmem_ready=1 SHALL give a normal cycle and a transition to RUN.
REQ-019 When the wait counter reaches MEM_TIMEOUT, the block SHALL set mem_timeout_err and go to TIMEOUT_RESUME.
REQ-020 TIMEOUT_RESUME SHALL last one cycle, ignore dmem_ready, enable all writes, then go to RUN.
REQ-021 Redirect (mem_pcsrc!=0, no memory wait) SHALL assert if_id_reset, id_ex_reset and ex_mem_reset with all write enables 1.
REQ-022 Load-use hazard SHALL be ex_memread=1, ex_rt!=0, and (ex_rt==id_rs or (id_uses_rt and ex_rt==id_rt)).
REQ-023 On load-use: pc_write=0, if_id_write=0, id_ex_reset=1, and ex_mem_write and mem_wb_write SHALL be 1.
REQ-024 Normal cycle: all write enables SHALL be 1 and all resets 0.
REQ-025 Redirect and load-use in the same cycle SHALL be treated as redirect only.
REQ-026 Register 0 SHALL never cause a stall.

Reset
REQ-027 During reset: state=RUN, wait counter=0, mem_timeout_err=0, all write enables 0, all resets 1.
REQ-028 Reset asserted in MEM_WAIT SHALL abandon the wait in the same edge, without setting the error.

Configuration
REQ-029 With HAZARD_PERF_EN defined, the block SHALL add outputs stall_cnt, flush_cnt and wait_cnt (each PERF_W).
  - Counters SHALL increment on load-use, redirect and MEM_WAIT cycles respectively.
  - Counters SHALL saturate at all-ones and clear on reset.
REQ-030 Without HAZARD_PERF_EN, these ports and counters SHALL be absent and behaviour otherwise identical.

Structure
REQ-031 The state encoding and the reset/default value of MEM_TIMEOUT SHALL live in shared package pipeline_pkg.
REQ-032 The combinational load-use comparator SHALL be sub-module load_use_detect.

Verification
REQ-033 Load-use: ex_memread=1, ex_rt=5, id_rs=5 -> one cycle pc_write=0, if_id_write=0, id_ex_reset=1; then, with ex_memread=0, a normal cycle.
REQ-034 ex_memread=1, ex_rt=0, id_rs=0 -> no stall.
REQ-035 mem_pcsrc=2 together with load-use hazard -> three resets=1, pc_write=1, id_ex_write=1.
REQ-036 dmem_req=1 with dmem_ready low for 4 cycles -> 4 frozen cycles, then RUN with mem_timeout_err=0.
REQ-037 dmem_ready never rises -> after 15 MEM_WAIT cycles: TIMEOUT_RESUME for 1 cycle, mem_timeout_err stays 1 until reset.
REQ-038 reset pulsed in MEM_WAIT -> next state RUN, all resets asserted during reset, perf counters 0.

Source files
------------

// File: rtl/pipeline_pkg.sv
// Shared definitions for the pipeline hazard controller: FSM encoding,
// default memory-wait timeout and the pipeline control bundle.
package pipeline_pkg;

  localparam logic [1:0] ST_RUN            = 2'd0;
  localparam logic [1:0] ST_MEM_WAIT       = 2'd1;
  localparam logic [1:0] ST_TIMEOUT_RESUME = 2'd2;
  localparam logic [1:0] ST_UNUSED         = 2'd3;

  localparam int MEM_TIMEOUT_DEFAULT = 15;

  typedef struct packed {
    logic pc_write;
    logic if_id_write;
    logic id_ex_write;
    logic ex_mem_write;
    logic mem_wb_write;
    logic if_id_reset;
    logic id_ex_reset;
    logic ex_mem_reset;
  } ctrl_t;

  // Bubble insertion keeps ID/EX writing so the cleared value is captured.
  localparam ctrl_t CTRL_NORMAL = ctrl_t'(8'b11111_000);
  localparam ctrl_t CTRL_FREEZE = ctrl_t'(8'b00000_000);
  localparam ctrl_t CTRL_FLUSH  = ctrl_t'(8'b11111_111);
  localparam ctrl_t CTRL_STALL  = ctrl_t'(8'b00111_010);
  localparam ctrl_t CTRL_RESET  = ctrl_t'(8'b00000_111);

endpackage

// File: rtl/load_use_detect.sv
// Combinational load-use comparator between the load in EX and the
// source registers of the instruction in ID; register 0 never matches.
module load_use_detect (
  input  logic [4:0] id_rs,
  input  logic [4:0] id_rt,
  input  logic       id_uses_rt,
  input  logic       ex_memread,
  input  logic [4:0] ex_rt,
  output logic       hazard
);

  logic rs_match_s;
  logic rt_match_s;

  assign rs_match_s = (ex_rt == id_rs);
  assign rt_match_s = id_uses_rt && (ex_rt == id_rt);
  assign hazard     = ex_memread && (ex_rt != 5'd0) && (rs_match_s || rt_match_s);

endmodule

// File: rtl/pipeline_hazard_ctrl.sv
// Pipeline hazard controller: memory-wait freeze with timeout, redirect
// flush and load-use stall. Define HAZARD_PERF_EN for performance counters.
module pipeline_hazard_ctrl
  import pipeline_pkg::*;
#(
  parameter int MEM_TIMEOUT = MEM_TIMEOUT_DEFAULT,
  parameter int PERF_W      = 16
) (
  input  logic        clock,
  input  logic        reset,
  input  logic [4:0]  id_rs,
  input  logic [4:0]  id_rt,
  input  logic        id_uses_rt,
  input  logic        ex_memread,
  input  logic [4:0]  ex_rt,
  input  logic [1:0]  mem_pcsrc,
  input  logic        dmem_req,
  input  logic        dmem_ready,
  output logic        pc_write,
  output logic        if_id_write,
  output logic        id_ex_write,
  output logic        ex_mem_write,
  output logic        mem_wb_write,
  output logic        if_id_reset,
  output logic        id_ex_reset,
  output logic        ex_mem_reset,
  output logic        mem_timeout_err,
  output logic [1:0]  state_o
`ifdef HAZARD_PERF_EN
  ,
  output logic [PERF_W-1:0] stall_cnt,
  output logic [PERF_W-1:0] flush_cnt,
  output logic [PERF_W-1:0] wait_cnt
`endif
);

  localparam int CNT_W = (MEM_TIMEOUT < 1) ? 1 : $clog2(MEM_TIMEOUT + 1);

  logic [1:0]       state_q, state_d;
  logic [CNT_W-1:0] wait_q, wait_d;
  logic             err_q, err_d;

  logic  load_use_s;
  logic  mem_wait_s;
  logic  redirect_s;
  logic  stall_s;
  logic  flush_s;
  logic  [CNT_W-1:0] wait_inc_s;
  ctrl_t ctrl_s;

  load_use_detect u_load_use_detect (
    .id_rs      (id_rs),
    .id_rt      (id_rt),
    .id_uses_rt (id_uses_rt),
    .ex_memread (ex_memread),
    .ex_rt      (ex_rt),
    .hazard     (load_use_s)
  );

  // The resume cycle ignores dmem_ready so the pipeline is guaranteed to advance.
  assign mem_wait_s = dmem_req && !dmem_ready && (state_q != ST_TIMEOUT_RESUME);
  assign redirect_s = (mem_pcsrc != 2'b00);
  assign wait_inc_s = wait_q + {{(CNT_W-1){1'b0}}, 1'b1};

  // Priority decode of the pipeline controls for this cycle.
  always_comb begin
    ctrl_s  = CTRL_NORMAL;
    stall_s = 1'b0;
    flush_s = 1'b0;
    if (reset) begin
      ctrl_s = CTRL_RESET;
    end else if (mem_wait_s) begin
      ctrl_s = CTRL_FREEZE;
    end else if (redirect_s) begin
      ctrl_s  = CTRL_FLUSH;
      flush_s = 1'b1;
    end else if (load_use_s && (state_q != ST_TIMEOUT_RESUME)) begin
      ctrl_s  = CTRL_STALL;
      stall_s = 1'b1;
    end else begin
      ctrl_s = CTRL_NORMAL;
    end
  end

  // Next-state logic for the memory-wait FSM, wait counter and sticky error.
  always_comb begin
    state_d = state_q;
    wait_d  = wait_q;
    err_d   = err_q;
    case (state_q)
      ST_MEM_WAIT: begin
        if (mem_wait_s) begin
          wait_d = wait_inc_s;
          if (wait_inc_s == CNT_W'(MEM_TIMEOUT)) begin
            state_d = ST_TIMEOUT_RESUME;
            err_d   = 1'b1;
          end else begin
            state_d = ST_MEM_WAIT;
          end
        end else begin
          state_d = ST_RUN;
        end
      end
      ST_TIMEOUT_RESUME: begin
        state_d = ST_RUN;
      end
      default: begin
        // RUN and the unused encoding both behave as RUN.
        if (mem_wait_s) begin
          state_d = ST_MEM_WAIT;
          wait_d  = '0;
        end else begin
          state_d = ST_RUN;
        end
      end
    endcase
  end

  // State registers; reset abandons any wait without flagging an error.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= ST_RUN;
      wait_q  <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      wait_q  <= wait_d;
      err_q   <= err_d;
    end
  end

  assign pc_write        = ctrl_s.pc_write;
  assign if_id_write     = ctrl_s.if_id_write;
  assign id_ex_write     = ctrl_s.id_ex_write;
  assign ex_mem_write    = ctrl_s.ex_mem_write;
  assign mem_wb_write    = ctrl_s.mem_wb_write;
  assign if_id_reset     = ctrl_s.if_id_reset;
  assign id_ex_reset     = ctrl_s.id_ex_reset;
  assign ex_mem_reset    = ctrl_s.ex_mem_reset;
  assign mem_timeout_err = err_q;
  assign state_o         = state_q;

`ifdef HAZARD_PERF_EN
  logic [PERF_W-1:0] stall_cnt_q, flush_cnt_q, wait_cnt_q;

  // Saturating event counters for load-use stalls, redirects and wait cycles.
  always_ff @(posedge clock) begin
    if (reset) begin
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
      wait_cnt_q  <= '0;
    end else begin
      if (stall_s && (stall_cnt_q != {PERF_W{1'b1}})) begin
        stall_cnt_q <= stall_cnt_q + {{(PERF_W-1){1'b0}}, 1'b1};
      end
      if (flush_s && (flush_cnt_q != {PERF_W{1'b1}})) begin
        flush_cnt_q <= flush_cnt_q + {{(PERF_W-1){1'b0}}, 1'b1};
      end
      if ((state_q == ST_MEM_WAIT) && (wait_cnt_q != {PERF_W{1'b1}})) begin
        wait_cnt_q <= wait_cnt_q + {{(PERF_W-1){1'b0}}, 1'b1};
      end
    end
  end

  assign stall_cnt = stall_cnt_q;
  assign flush_cnt = flush_cnt_q;
  assign wait_cnt  = wait_cnt_q;
`else
  logic unused_perf_s;
  assign unused_perf_s = stall_s ^ flush_s;
`endif

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Self-checking bench for pipeline_hazard_ctrl: vector table plus
// multi-cycle sequences, expectations routed through a scoreboard queue.
module tb_pipeline_hazard_ctrl;

  logic       clock = 1'b0;
  logic       reset;
  logic [4:0] id_rs, id_rt, ex_rt;
  logic       id_uses_rt, ex_memread, dmem_req, dmem_ready;
  logic [1:0] mem_pcsrc;
  logic       pc_write, if_id_write, id_ex_write, ex_mem_write, mem_wb_write;
  logic       if_id_reset, id_ex_reset, ex_mem_reset, mem_timeout_err;
  logic [1:0] state_o;
`ifdef HAZARD_PERF_EN
  logic [15:0] stall_cnt, flush_cnt, wait_cnt;
`endif

  pipeline_hazard_ctrl dut (
    .clock           (clock),
    .reset           (reset),
    .id_rs           (id_rs),
    .id_rt           (id_rt),
    .id_uses_rt      (id_uses_rt),
    .ex_memread      (ex_memread),
    .ex_rt           (ex_rt),
    .mem_pcsrc       (mem_pcsrc),
    .dmem_req        (dmem_req),
    .dmem_ready      (dmem_ready),
    .pc_write        (pc_write),
    .if_id_write     (if_id_write),
    .id_ex_write     (id_ex_write),
    .ex_mem_write    (ex_mem_write),
    .mem_wb_write    (mem_wb_write),
    .if_id_reset     (if_id_reset),
    .id_ex_reset     (id_ex_reset),
    .ex_mem_reset    (ex_mem_reset),
    .mem_timeout_err (mem_timeout_err),
    .state_o         (state_o)
`ifdef HAZARD_PERF_EN
    ,
    .stall_cnt       (stall_cnt),
    .flush_cnt       (flush_cnt),
    .wait_cnt        (wait_cnt)
`endif
  );

  always #5 clock = ~clock;

  // {pc, if_id, id_ex, ex_mem, mem_wb write ; if_id, id_ex, ex_mem reset}
  localparam logic [7:0] C_NORM   = 8'b11111_000;
  localparam logic [7:0] C_FREEZE = 8'b00000_000;
  localparam logic [7:0] C_FLUSH  = 8'b11111_111;
  localparam logic [7:0] C_STALL  = 8'b00111_010;
  localparam logic [7:0] C_RST    = 8'b00000_111;

  typedef struct {
    logic [4:0] rs, rt;
    logic       uses, mr;
    logic [4:0] ert;
    logic [1:0] pcsrc;
    logic       req, rdy, rst;
    logic [7:0] ctl;
    logic [1:0] st;
    logic       err;
  } vec_t;

  typedef struct packed {
    logic [7:0] ctl;
    logic [1:0] st;
    logic       err;
  } exp_t;

  exp_t exp_q[$];
  int   n_checks = 0;
  int   n_fail   = 0;

  function automatic vec_t mk(input logic [4:0] rs, input logic [4:0] rt,
                              input logic uses, input logic mr, input logic [4:0] ert,
                              input logic [1:0] pcsrc, input logic req, input logic rdy,
                              input logic rst, input logic [7:0] ctl,
                              input logic [1:0] st, input logic err);
    vec_t v;
    v.rs = rs; v.rt = rt; v.uses = uses; v.mr = mr; v.ert = ert; v.pcsrc = pcsrc;
    v.req = req; v.rdy = rdy; v.rst = rst; v.ctl = ctl; v.st = st; v.err = err;
    return v;
  endfunction

  // Drive one cycle, queue its expectation, compare mid-cycle, advance.
  task automatic apply(input vec_t v, input string name);
    exp_t e;
    exp_t got;
    id_rs = v.rs; id_rt = v.rt; id_uses_rt = v.uses; ex_memread = v.mr;
    ex_rt = v.ert; mem_pcsrc = v.pcsrc; dmem_req = v.req; dmem_ready = v.rdy;
    reset = v.rst;
    exp_q.push_back(exp_t'({v.ctl, v.st, v.err}));
    @(negedge clock);
    e   = exp_q.pop_front();
    got = exp_t'({pc_write, if_id_write, id_ex_write, ex_mem_write, mem_wb_write,
                  if_id_reset, id_ex_reset, ex_mem_reset, state_o, mem_timeout_err});
    n_checks++;
    if (got !== e) begin
      n_fail++;
      $display("FAIL %s: got ctl=%b state=%0d err=%b, expected ctl=%b state=%0d err=%b",
               name, got.ctl, got.st, got.err, e.ctl, e.st, e.err);
    end
    @(posedge clock);
    #1;
  endtask

`ifdef HAZARD_PERF_EN
  task automatic check_perf_zero(input string name);
    n_checks++;
    if ({stall_cnt, flush_cnt, wait_cnt} !== 48'd0) begin
      n_fail++;
      $display("FAIL %s: got stall=%0d flush=%0d wait=%0d, expected all 0",
               name, stall_cnt, flush_cnt, wait_cnt);
    end
  endtask
`endif

  vec_t  tbl[11];
  string tnames[11];

  initial begin
    //            rs     rt     use   mr    ert    pcsrc  req   rdy   rst   ctl      st    err
    tbl[0]  = mk(5'd0,  5'd0,  1'b0, 1'b0, 5'd0,  2'd0, 1'b0, 1'b0, 1'b0, C_NORM,  2'd0, 1'b0);
    tbl[1]  = mk(5'd5,  5'd2,  1'b0, 1'b1, 5'd5,  2'd0, 1'b0, 1'b0, 1'b0, C_STALL, 2'd0, 1'b0);
    tbl[2]  = mk(5'd1,  5'd7,  1'b1, 1'b1, 5'd7,  2'd0, 1'b0, 1'b0, 1'b0, C_STALL, 2'd0, 1'b0);
    tbl[3]  = mk(5'd1,  5'd7,  1'b0, 1'b1, 5'd7,  2'd0, 1'b0, 1'b0, 1'b0, C_NORM,  2'd0, 1'b0);
    tbl[4]  = mk(5'd0,  5'd3,  1'b0, 1'b1, 5'd0,  2'd0, 1'b0, 1'b0, 1'b0, C_NORM,  2'd0, 1'b0);
    tbl[5]  = mk(5'd4,  5'd0,  1'b1, 1'b1, 5'd0,  2'd0, 1'b0, 1'b0, 1'b0, C_NORM,  2'd0, 1'b0);
    tbl[6]  = mk(5'd9,  5'd1,  1'b1, 1'b0, 5'd9,  2'd0, 1'b0, 1'b0, 1'b0, C_NORM,  2'd0, 1'b0);
    tbl[7]  = mk(5'd5,  5'd2,  1'b0, 1'b1, 5'd5,  2'd2, 1'b0, 1'b0, 1'b0, C_FLUSH, 2'd0, 1'b0);
    tbl[8]  = mk(5'd3,  5'd4,  1'b0, 1'b0, 5'd6,  2'd1, 1'b0, 1'b0, 1'b0, C_FLUSH, 2'd0, 1'b0);
    tbl[9]  = mk(5'd3,  5'd4,  1'b1, 1'b0, 5'd6,  2'd3, 1'b1, 1'b1, 1'b0, C_FLUSH, 2'd0, 1'b0);
    tbl[10] = mk(5'd8,  5'd31, 1'b1, 1'b1, 5'd31, 2'd0, 1'b1, 1'b1, 1'b0, C_STALL, 2'd0, 1'b0);
    tnames  = '{"normal", "lu_rs", "lu_rt", "rt_not_used", "r0_rs", "r0_rt",
                "no_memread", "redirect_over_lu", "redirect1", "redirect3", "lu_mem_ready"};

    reset = 1'b1; id_rs = 5'd0; id_rt = 5'd0; id_uses_rt = 1'b0; ex_memread = 1'b0;
    ex_rt = 5'd0; mem_pcsrc = 2'd0; dmem_req = 1'b0; dmem_ready = 1'b0;
    @(posedge clock);
    #1;

    apply(mk(5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 2'd0, 1'b1, 1'b0, 1'b1, C_RST, 2'd0, 1'b0), "reset_state");
`ifdef HAZARD_PERF_EN
    check_perf_zero("perf_after_reset");
`endif

    for (int i = 0; i < 11; i++) apply(tbl[i], tnames[i]);

    // Load-use stall followed by the same instruction with the load gone.
    apply(mk(5'd5, 5'd0, 1'b0, 1'b1, 5'd5, 2'd0, 1'b0, 1'b0, 1'b0, C_STALL, 2'd0, 1'b0), "seq_lu_stall");
    apply(mk(5'd5, 5'd0, 1'b0, 1'b0, 5'd5, 2'd0, 1'b0, 1'b0, 1'b0, C_NORM,  2'd0, 1'b0), "seq_lu_release");

    // Four frozen cycles, then completion and back to RUN without error.
    apply(mk(5'd5, 5'd0, 1'b0, 1'b1, 5'd5, 2'd2, 1'b1, 1'b0, 1'b0, C_FREEZE, 2'd0, 1'b0), "wait_enter");
    for (int i = 0; i < 3; i++)
      apply(mk(5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 2'd0, 1'b1, 1'b0, 1'b0, C_FREEZE, 2'd1, 1'b0), "wait_hold");
    apply(mk(5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 2'd0, 1'b1, 1'b1, 1'b0, C_NORM, 2'd1, 1'b0), "wait_ready");
    apply(mk(5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 2'd0, 1'b0, 1'b0, 1'b0, C_NORM, 2'd0, 1'b0), "wait_back_run");

    // Memory never answers: 15 MEM_WAIT cycles, one resume cycle, sticky error.
    apply(mk(5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 2'd0, 1'b1, 1'b0, 1'b0, C_FREEZE, 2'd0, 1'b0), "to_enter");
    for (int i = 0; i < 15; i++)
      apply(mk(5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 2'd0, 1'b1, 1'b0, 1'b0, C_FREEZE, 2'd1, 1'b0), "to_wait");
    apply(mk(5'd5, 5'd0, 1'b0, 1'b1, 5'd5, 2'd0, 1'b1, 1'b0, 1'b0, C_NORM, 2'd2, 1'b1), "to_resume");
    apply(mk(5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 2'd0, 1'b0, 1'b0, 1'b0, C_NORM, 2'd0, 1'b1), "to_run_sticky");
    apply(mk(5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 2'd1, 1'b0, 1'b0, 1'b0, C_FLUSH, 2'd0, 1'b1), "to_sticky2");

    // Reset pulsed inside MEM_WAIT abandons the wait and clears the error.
    apply(mk(5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 2'd0, 1'b1, 1'b0, 1'b0, C_FREEZE, 2'd0, 1'b1), "rst_wait_enter");
    apply(mk(5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 2'd0, 1'b1, 1'b0, 1'b0, C_FREEZE, 2'd1, 1'b1), "rst_wait_hold");
    apply(mk(5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 2'd0, 1'b1, 1'b0, 1'b1, C_RST, 2'd1, 1'b1), "rst_in_wait");
    apply(mk(5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 2'd0, 1'b0, 1'b0, 1'b0, C_NORM, 2'd0, 1'b0), "rst_after");
`ifdef HAZARD_PERF_EN
    check_perf_zero("perf_after_wait_reset");
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
